// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin sharing of one 8-bit combinational barrel shifter
// between two valid/ready requesters. A three-state FSM latches the granted
// request, registers the shift result and holds it until the response is taken.

module barrelshifter (
    input  logic [7:0] in,
    input  logic [2:0] shamt,
    input  logic       dir,
    output logic [7:0] out
);

    // Logical shift with zero fill; dir=1 shifts left, dir=0 shifts right.
    always_comb begin
        if (dir) begin
            out = in << shamt;
        end else begin
            out = in >> shamt;
        end
    end

endmodule

module shift_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [7:0]       req_in0,
    input  logic [7:0]       req_in1,
    input  logic [2:0]       req_shamt0,
    input  logic [2:0]       req_shamt1,
    input  logic             req_dir0,
    input  logic             req_dir1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [7:0]       rsp_data,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t           state_q;
    logic             last_grant_q;
    logic             cur_id_q;
    logic [7:0]       op_in_q;
    logic [2:0]       op_shamt_q;
    logic             op_dir_q;
    logic [7:0]       rsp_data_q;
    logic [1:0]       rsp_valid_q;
    logic             busy_q;
    logic [CNT_W-1:0] ops_done_q;
    logic [CNT_W-1:0] ops_done_d;

    logic             grant_s;
    logic [1:0]       req_ready_s;
    logic             req_fire_s;
    logic             rsp_fire_s;
    logic [7:0]       shift_out_s;

    barrelshifter u_shifter (
        .in    (op_in_q),
        .shamt (op_shamt_q),
        .dir   (op_dir_q),
        .out   (shift_out_s)
    );

    // Round-robin grant: a lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        grant_s = 1'b0;
        case (req_valid)
            2'b01:   grant_s = 1'b0;
            2'b10:   grant_s = 1'b1;
            2'b11:   grant_s = ~last_grant_q;
            default: grant_s = 1'b0;
        endcase
    end

    // Ready only in IDLE and only toward the granted, valid requester.
    always_comb begin
        req_ready_s = 2'b00;
        if ((state_q == ST_IDLE) && (req_valid != 2'b00)) begin
            req_ready_s = grant_s ? 2'b10 : 2'b01;
        end else begin
            req_ready_s = 2'b00;
        end
    end

    assign req_fire_s = |(req_valid & req_ready_s);
    assign rsp_fire_s = cur_id_q ? rsp_ready[1] : rsp_ready[0];
    assign ops_done_d = ops_done_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // Operation FSM: capture request, register shifter result, hold until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            cur_id_q     <= 1'b0;
            op_in_q      <= 8'h00;
            op_shamt_q   <= 3'd0;
            op_dir_q     <= 1'b0;
            rsp_data_q   <= 8'h00;
            rsp_valid_q  <= 2'b00;
            busy_q       <= 1'b0;
            ops_done_q   <= {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_fire_s) begin
                        op_in_q      <= grant_s ? req_in1 : req_in0;
                        op_shamt_q   <= grant_s ? req_shamt1 : req_shamt0;
                        op_dir_q     <= grant_s ? req_dir1 : req_dir0;
                        cur_id_q     <= grant_s;
                        last_grant_q <= grant_s;
                        busy_q       <= 1'b1;
                        state_q      <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    rsp_data_q  <= shift_out_s;
                    rsp_valid_q <= cur_id_q ? 2'b10 : 2'b01;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_fire_s) begin
                        rsp_valid_q <= 2'b00;
                        ops_done_q  <= ops_done_d;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 2'b00;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign ops_done  = ops_done_q;

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares a single 8-bit combinational `barrelshifter` (ports `in`, `shamt[2:0]`, `dir`, `out`; `dir`=1 logical left, 0 logical right, zero fill) between two requesters. Each requester has a valid/ready request channel and a valid/ready response channel. A round-robin arbiter grants one request at a time. A three-state FSM captures the request operands, registers the shifter result and holds it until the requester accepts it. The block sits between the datapath clients and the shifter instance, which it instantiates internally.

## Interface
- `CNT_W`, default 16: width of the completed-operation counter.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid[1:0]` input 2: request valid, one bit per requester.
- `req_ready[1:0]` output 2: request accepted this cycle, one bit per requester.
- `req_in0`, `req_in1` input 8 each: operand for requester 0/1.
- `req_shamt0`, `req_shamt1` input 3 each: shift amount, 0–7.
- `req_dir0`, `req_dir1` input 1 each: 1 = left, 0 = right.
- `rsp_valid[1:0]` output 2: result valid for the requester that was granted.
- `rsp_ready[1:0]` input 2: response accepted.
- `rsp_data` output 8: registered shift result, shared by both requesters and qualified by `rsp_valid`.
- `busy` output 1: high whenever state ≠ IDLE.
- `ops_done` output CNT_W: count of completed response handshakes; wraps to 0 after all-ones.

## Operation
- FSM states: IDLE, SHIFT, RESP.
- IDLE: `grant` is computed combinationally.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not in `last_grant` is granted.
  - `req_ready[grant]` = 1 and the other `req_ready` bit = 0.
  - On `req_valid[g] && req_ready[g]`: latch operand, shamt, dir and `cur_id`=g; set `last_grant`=g; go to SHIFT.
- SHIFT: the shifter is driven from the latched operands. At the edge, `rsp_data` <= shifter `out`; go to RESP.
- RESP: `rsp_valid[cur_id]` = 1 and the other `rsp_valid` bit = 0.
  - On `rsp_ready[cur_id]`: increment `ops_done` and go to IDLE.
  - `rsp_ready` on the non-granted bit is ignored.
- `req_ready` is 0 in SHIFT and RESP. Only one operation is in flight at a time.
- Request payload must stay stable while `req_valid` is high and `req_ready` is low. A requester may drop `req_valid` before it is granted; this has no effect.
- Arithmetic: logical shift, bits shifted out are discarded, zero fill. `shamt`=0 passes the operand through unchanged.

## Timing
- Reset values: state IDLE, `last_grant`=1 (so requester 0 wins the first tie), `rsp_data`=8'h00, `rsp_valid`=2'b00, `ops_done`=0, `busy`=0. `req_ready` follows the IDLE grant logic immediately after reset.
- Latency: request accepted at edge T0; SHIFT during cycle T0–T1; `rsp_valid` and `rsp_data` valid from T1. With `rsp_ready` already high, the handshake completes at T2 and a new request can be accepted at T3.
- Minimum spacing between operations is 3 cycles. Response backpressure stalls the FSM in RESP indefinitely, with `rsp_data` held stable.
- A new request arriving during SHIFT or RESP waits. The arbitration decision uses `last_grant` as it stands when the FSM re-enters IDLE.
- Reset asserted mid-operation (SHIFT or RESP) returns all registers to their reset values asynchronously. The in-flight result is dropped and no response is issued.
- `ops_done` increments exactly once per response handshake and never on request acceptance.

## Test plan
- Single left shift: requester 0 sends `in`=8'b00000001, shamt 7, dir 1 → `req_ready[0]` at T0, `rsp_valid`=2'b01 and `rsp_data`=8'b10000000 at T1, `ops_done`=1 after the handshake.
- Single right shift: requester 1 sends 8'b00001101, shamt 2, dir 0 → `rsp_valid`=2'b10 and `rsp_data`=8'b00000011.
- Tie and fairness: both requesters hold valid continuously from reset, with requester 0 = (8'hFF, 4, 1) and requester 1 = (8'hFF, 4, 0).
  - Grants must alternate 0, 1, 0, 1.
  - `rsp_data` must alternate 8'hF0, 8'h0F.
  - Each operation takes 3 cycles with `rsp_ready` tied high.
- Backpressure: hold `rsp_ready[0]` low for 5 cycles in RESP → `rsp_data` stays stable, `req_ready`=0, `busy`=1; releasing `rsp_ready[0]` completes the handshake.
- Reset mid-operation: deassert `rst_n` during SHIFT → all outputs return to reset values without waiting for a clock edge, and no `rsp_valid` pulse occurs. After release, a tie grants requester 0.
- Edge values: shamt 0 with 8'hA5 returns 8'hA5. Driving 2^CNT_W handshakes (with `CNT_W` overridden to 4) makes `ops_done` wrap to 0.
